// File: rtl/cache_defs.sv
// Shared definitions for the write-through cache controller: state codes,
// default memory latency and the latency counter width.
package cache_defs;

  localparam int MEM_CYCLES_DEFAULT = 4;
  localparam int CNT_W              = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_MISS = 3'd1,
    ST_REFILL    = 3'd2,
    ST_WRITE_MEM = 3'd3,
    ST_WRITE_ACK = 3'd4
  } state_t;

  // States that occupy main memory and advance the latency counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_READ_MISS) || (s == ST_WRITE_MEM);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Main-memory latency counter: counts enabled cycles from 0 and flags the
// last one. Saturates at the terminal value, so it never wraps.
module mem_wait_counter
  import cache_defs::*;
#(
  parameter int TC_VALUE = MEM_CYCLES_DEFAULT - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_CNT = CNT_W'(TC_VALUE);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != TC_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc = (r_count == TC_CNT);

endmodule

// File: rtl/cache_controller_fsm.sv
// Write-through, no-write-allocate cache controller. Read hits complete in
// IDLE with no stall; misses and writes wait MEM_CYCLES on main memory.
module cache_controller_fsm
  import cache_defs::*;
#(
  parameter int MEM_CYCLES = MEM_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic       hit,
  output logic       stall,
  output logic       mem_read,
  output logic       mem_write,
  output logic       cache_read,
  output logic       cache_write,
  output logic       invalidate,
  output logic [2:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_cnt_en;
  logic   w_cnt_clr;
  logic   w_tc;

  // Clearing on the terminal count leaves the counter at 0 in REFILL/WRITE_ACK.
  mem_wait_counter #(
    .TC_VALUE (MEM_CYCLES - 1)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    invalidate  = 1'b0;
    w_cnt_en    = is_mem_state(r_state);
    w_cnt_clr   = !is_mem_state(r_state);

    unique case (r_state)
      ST_IDLE: begin
        // A simultaneous read and write is served as a read only.
        if (cpu_read) begin
          if (hit) begin
            cache_read = 1'b1;
          end else begin
            stall  = 1'b1;
            w_next = ST_READ_MISS;
          end
        end else if (cpu_write) begin
          stall      = 1'b1;
          invalidate = hit;
          w_next     = ST_WRITE_MEM;
        end
      end
      ST_READ_MISS: begin
        mem_read = 1'b1;
        stall    = 1'b1;
        if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        cache_write = 1'b1;
        stall       = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_WRITE_MEM: begin
        mem_write = 1'b1;
        stall     = 1'b1;
        if (w_tc) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_WRITE_ACK;
        end
      end
      ST_WRITE_ACK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_cache_controller_fsm.sv
// Bench for cache_controller_fsm: two instances (default latency and
// MEM_CYCLES=1) checked cycle by cycle against a transaction-schedule model.
module tb_cache_controller_fsm;
  import cache_defs::*;

  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] cpu_read = '0;
  logic [NL-1:0] cpu_write = '0;
  logic [NL-1:0] hit = '0;
  logic [NL-1:0] stall, mem_read, mem_write, cache_read, cache_write, invalidate;
  logic [2:0]    state [NL];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_dut
      cache_controller_fsm #(
        .MEM_CYCLES ((gi == 0) ? MEM_CYCLES_DEFAULT : 1)
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_read    (cpu_read[gi]),
        .cpu_write   (cpu_write[gi]),
        .hit         (hit[gi]),
        .stall       (stall[gi]),
        .mem_read    (mem_read[gi]),
        .mem_write   (mem_write[gi]),
        .cache_read  (cache_read[gi]),
        .cache_write (cache_write[gi]),
        .invalidate  (invalidate[gi]),
        .state       (state[gi])
      );
    end
  endgenerate

  // Vector layout: {state[2:0], stall, mem_read, mem_write, cache_read, cache_write, invalidate}
  localparam int B_STALL = 5;
  localparam int B_MR    = 4;
  localparam int B_MW    = 3;
  localparam int B_CR    = 2;
  localparam int B_CW    = 1;
  localparam int B_INV   = 0;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] plan [NL][$];
  logic [8:0] exp_v [NL];
  logic [8:0] got_v [NL];
  logic       req_on [NL];

  function automatic int mc_of(input int l);
    return (l == 0) ? MEM_CYCLES_DEFAULT : 1;
  endfunction

  function automatic logic [8:0] mk(input logic [2:0] s, input logic st, input logic mr,
                                     input logic mw, input logic cr, input logic cw,
                                     input logic inv);
    return {s, st, mr, mw, cr, cw, inv};
  endfunction

  function automatic logic [8:0] sample(input int l);
    return {state[l], stall[l], mem_read[l], mem_write[l], cache_read[l], cache_write[l],
            invalidate[l]};
  endfunction

  // A request accepted in IDLE schedules its whole remaining transaction.
  task automatic model_step(input int l, output logic [8:0] e);
    e = '0;
    if (plan[l].size() > 0) begin
      e = plan[l].pop_front();
    end else if (cpu_read[l]) begin
      if (hit[l]) begin
        e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        e = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (rst_n) begin
          repeat (mc_of(l)) plan[l].push_back(mk(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
          plan[l].push_back(mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
      end
    end else if (cpu_write[l]) begin
      e = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hit[l]);
      if (rst_n) begin
        repeat (mc_of(l)) plan[l].push_back(mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        plan[l].push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic check_cycle();
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      model_step(l, exp_v[l]);
      got_v[l] = sample(l);
      n_vec++;
      assert (got_v[l] === exp_v[l]) else begin
        n_err++;
        $error("FAIL cycle lane%0d t=%0t: observed %b expected %b", l, $time, got_v[l], exp_v[l]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int l, input int observed, input int expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s lane%0d: observed %0d expected %0d", tag, l, observed, expected);
    end
  endtask

  // Drop rst_n between edges and confirm the effect is immediate.
  task automatic async_reset();
    logic [5:0] r;
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      plan[l].delete();
      r = {state[l], mem_read[l], mem_write[l], cache_write[l]};
      n_vec++;
      assert (r === 6'd0) else begin
        n_err++;
        $error("FAIL async_reset lane%0d: observed %b expected %b", l, r, 6'd0);
      end
    end
    check_cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_directed(input string tag, input logic rd, input logic wr, input logic h);
    int   c_st [NL], c_mr [NL], c_mw [NL], c_cw [NL], c_inv [NL], fin_state [NL], fin_cr [NL];
    logic done [NL];
    for (int l = 0; l < NL; l++) begin
      c_st[l] = 0; c_mr[l] = 0; c_mw[l] = 0; c_cw[l] = 0; c_inv[l] = 0;
      fin_state[l] = -1; fin_cr[l] = -1; done[l] = 1'b0;
      cpu_read[l] = rd; cpu_write[l] = wr; hit[l] = h;
    end
    for (int cyc = 0; cyc < 40 && !(done[0] && done[1]); cyc++) begin
      check_cycle();
      for (int l = 0; l < NL; l++) begin
        if (!done[l]) begin
          c_st[l]  += int'(got_v[l][B_STALL]);
          c_mr[l]  += int'(got_v[l][B_MR]);
          c_mw[l]  += int'(got_v[l][B_MW]);
          c_cw[l]  += int'(got_v[l][B_CW]);
          c_inv[l] += int'(got_v[l][B_INV]);
          if (got_v[l][B_CW]) hit[l] = 1'b1;
          if (!exp_v[l][B_STALL]) begin
            done[l]      = 1'b1;
            fin_state[l] = int'(got_v[l][8:6]);
            fin_cr[l]    = int'(got_v[l][B_CR]);
            cpu_read[l]  = 1'b0;
            cpu_write[l] = 1'b0;
            hit[l]       = 1'b0;
          end
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      chk({tag, "_done"}, l, int'(done[l]), 1);
      chk({tag, "_stall_cycles"}, l, c_st[l],
          rd ? (h ? 0 : mc_of(l) + 2) : mc_of(l) + 1);
      chk({tag, "_mem_read_cycles"}, l, c_mr[l], (rd && !h) ? mc_of(l) : 0);
      chk({tag, "_mem_write_cycles"}, l, c_mw[l], rd ? 0 : mc_of(l));
      chk({tag, "_cache_write_cycles"}, l, c_cw[l], (rd && !h) ? 1 : 0);
      chk({tag, "_invalidate_cycles"}, l, c_inv[l], (!rd && h) ? 1 : 0);
      chk({tag, "_final_state"}, l, fin_state[l], rd ? 0 : 4);
      chk({tag, "_final_cache_read"}, l, fin_cr[l], rd ? 1 : 0);
    end
  endtask

  initial begin
    int kind;
    for (int l = 0; l < NL; l++) req_on[l] = 1'b0;

    // Held in reset with idle inputs: all outputs zero.
    #1;
    check_cycle();
    check_cycle();
    rst_n = 1'b1;
    check_cycle();

    run_directed("read_hit", 1'b1, 1'b0, 1'b1);
    run_directed("read_miss", 1'b1, 1'b0, 1'b0);
    run_directed("write_hit", 1'b0, 1'b1, 1'b1);
    run_directed("write_miss", 1'b0, 1'b1, 1'b0);
    run_directed("read_write_miss", 1'b1, 1'b1, 1'b0);

    // Reset during the second cycle of a read miss abandons the refill.
    for (int l = 0; l < NL; l++) begin
      cpu_read[l] = 1'b1; cpu_write[l] = 1'b0; hit[l] = 1'b0;
    end
    check_cycle();
    check_cycle();
    async_reset();
    for (int l = 0; l < NL; l++) cpu_read[l] = 1'b0;
    repeat (3) check_cycle();

    // Random CPU traffic honouring the hold-until-unstalled protocol.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check_cycle();
      for (int l = 0; l < NL; l++) begin
        if (req_on[l] && !exp_v[l][B_STALL]) req_on[l] = 1'b0;
        if (!req_on[l]) begin
          kind         = int'($urandom_range(0, 3));
          cpu_read[l]  = (kind == 1) || (kind == 3);
          cpu_write[l] = (kind >= 2);
          req_on[l]    = (kind != 0);
        end
        hit[l] = exp_v[l][B_CW] ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 2) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
